// File: rtl/z80_bus_arbiter_if.sv
// Z80 master-side bus type and the arbiter's bundled request/grant/bus interface.
// The arbiter uses the master modport; the requesters/CPU side uses slave.
package z80_bus_pkg;
  typedef struct packed {
    logic        mreqn;
    logic        iorqn;
    logic        rdn;
    logic        wrn;
    logic        inta;
    logic [15:0] addr;
    logic [7:0]  dmaster;
  } z80_master_bus_t;
endpackage

interface z80_bus_arbiter_if
  import z80_bus_pkg::*;
#(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]                req;
  logic [NREQ-1:0]                ack;
  z80_master_bus_t [NREQ-1:0]     m_ibus;
  z80_master_bus_t                sys_obus;
  logic                           bus_oe;
  logic                           cpu_busrq_n;
  logic                           cpu_busack_n;
  logic [$clog2(NREQ+1)-1:0]      owner;

  modport master (
    input  req, m_ibus, cpu_busack_n,
    output ack, sys_obus, bus_oe, cpu_busrq_n, owner
  );

  modport slave (
    output req, m_ibus, cpu_busack_n,
    input  ack, sys_obus, bus_oe, cpu_busrq_n, owner
  );
endinterface

// File: rtl/z80_bus_arbiter.sv
// Round-robin arbiter sharing the Z80 system bus between the CPU and NREQ DMA masters,
// with a guaranteed CPU slot between DMA tenures (CPU_SLOT=0 allows direct handoff).
module z80_bus_arbiter
  import z80_bus_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int CPU_SLOT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  z80_bus_arbiter_if.master   bus
);

  localparam int OW = $clog2(NREQ + 1);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;

  typedef enum logic [4:0] {
    ST_CPU     = 5'b00001,
    ST_REQ     = 5'b00010,
    ST_GRANT   = 5'b00100,
    ST_HANDOFF = 5'b01000,
    ST_RELEASE = 5'b10000
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_win;
  logic [NREQ-1:0] r_ack;
  logic            r_bus_oe;
  logic            r_busrq_n;
  logic [OW-1:0]   r_owner;
  logic [15:0]     r_hold_addr;
  logic [7:0]      r_hold_data;

  state_t          w_state_nx;
  logic [PW-1:0]   w_rr_nx;
  logic [CW-1:0]   w_cnt_nx;
  logic [CW-1:0]   w_cnt_dec;
  logic [PW-1:0]   w_win_nx;
  logic [NREQ-1:0] w_ack_nx;
  logic            w_oe_nx;
  logic            w_busrq_n_nx;
  logic [OW-1:0]   w_owner_nx;
  logic [PW:0]     w_pick;
  z80_master_bus_t w_sel;
  z80_master_bus_t w_sys;

  // First asserted request scanning upward from ptr with wrap; MSB flags "found".
  function automatic logic [PW:0] f_pick(input logic [NREQ-1:0] rq, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int          j;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (rq[j]) res = {1'b1, PW'(j)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] w);
    if (int'(w) == NREQ - 1) return '0;
    else return w + PW'(1);
  endfunction

  assign w_pick    = f_pick(bus.req, r_rr_ptr);
  assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - CW'(1);

  // Next-state, arbitration bookkeeping and next values of the registered outputs.
  always_comb begin
    w_state_nx = r_state;
    w_rr_nx    = r_rr_ptr;
    w_cnt_nx   = r_cnt;
    w_win_nx   = r_win;
    case (r_state)
      ST_CPU: begin
        w_cnt_nx = w_cnt_dec;
        // The request is forwarded on the same edge the slot counter reaches zero.
        if ((w_cnt_dec == '0) && (|bus.req)) w_state_nx = ST_REQ;
        else w_state_nx = ST_CPU;
      end
      ST_REQ: begin
        if (!bus.cpu_busack_n) begin
          if (w_pick[PW]) begin
            w_state_nx = ST_GRANT;
            w_win_nx   = w_pick[PW-1:0];
            w_rr_nx    = f_next_ptr(w_pick[PW-1:0]);
          end else begin
            w_state_nx = ST_RELEASE;
          end
        end else begin
          w_state_nx = ST_REQ;
        end
      end
      ST_GRANT: begin
        if (!bus.req[r_win]) begin
          if ((CPU_SLOT == 0) && (|bus.req)) w_state_nx = ST_HANDOFF;
          else w_state_nx = ST_RELEASE;
        end else begin
          w_state_nx = ST_GRANT;
        end
      end
      ST_HANDOFF: begin
        if (w_pick[PW]) begin
          w_state_nx = ST_GRANT;
          w_win_nx   = w_pick[PW-1:0];
          w_rr_nx    = f_next_ptr(w_pick[PW-1:0]);
        end else begin
          w_state_nx = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (bus.cpu_busack_n) begin
          w_state_nx = ST_CPU;
          w_cnt_nx   = CW'(CPU_SLOT);
        end else begin
          w_state_nx = ST_RELEASE;
        end
      end
      default: begin
        w_state_nx = ST_CPU;
        w_cnt_nx   = '0;
      end
    endcase

    for (int k = 0; k < NREQ; k++) begin
      w_ack_nx[k] = (w_state_nx == ST_GRANT) && (w_win_nx == PW'(k));
    end
    w_oe_nx      = (w_state_nx == ST_GRANT);
    w_busrq_n_nx = !((w_state_nx == ST_REQ) || (w_state_nx == ST_GRANT) ||
                     (w_state_nx == ST_HANDOFF));
    w_owner_nx   = (w_state_nx == ST_GRANT) ? (OW'(w_win_nx) + OW'(1)) : OW'(0);
  end

  // State and registered outputs; reset aborts any tenure without a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CPU;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_win     <= '0;
      r_ack     <= '0;
      r_bus_oe  <= 1'b0;
      r_busrq_n <= 1'b1;
      r_owner   <= '0;
    end else if (cen) begin
      r_state   <= w_state_nx;
      r_rr_ptr  <= w_rr_nx;
      r_cnt     <= w_cnt_nx;
      r_win     <= w_win_nx;
      r_ack     <= w_ack_nx;
      r_bus_oe  <= w_oe_nx;
      r_busrq_n <= w_busrq_n_nx;
      r_owner   <= w_owner_nx;
    end
  end

  assign w_sel = bus.m_ibus[r_win];

  // Remember the last driven address/data so they hold once the bus is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_addr <= 16'h0000;
      r_hold_data <= 8'h00;
    end else if (cen && r_bus_oe) begin
      r_hold_addr <= w_sel.addr;
      r_hold_data <= w_sel.dmaster;
    end
  end

  // Zero-latency mux of the granted master; idle bus parks control lines high.
  always_comb begin
    w_sys = w_sel;
    if (r_bus_oe) begin
      w_sys = w_sel;
    end else begin
      w_sys.mreqn   = 1'b1;
      w_sys.iorqn   = 1'b1;
      w_sys.rdn     = 1'b1;
      w_sys.wrn     = 1'b1;
      w_sys.inta    = 1'b0;
      w_sys.addr    = r_hold_addr;
      w_sys.dmaster = r_hold_data;
    end
  end

  assign bus.sys_obus    = w_sys;
  assign bus.ack         = r_ack;
  assign bus.bus_oe      = r_bus_oe;
  assign bus.cpu_busrq_n = r_busrq_n;
  assign bus.owner       = r_owner;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed vector bench: one arbiter with CPU_SLOT=4 and one with CPU_SLOT=0 (handoff).
module tb_z80_bus_arbiter;
  import z80_bus_pkg::*;

  typedef struct {
    logic [1:0]  req;
    logic        bak;
    logic        cen;
    logic [1:0]  ack;
    logic        brq;
    logic        oe;
    logic [1:0]  own;
    logic [15:0] addr;
  } vec_t;

  logic clk;
  logic rst_n;
  logic cen;
  int   n_pass;
  int   n_total;

  z80_bus_arbiter_if #(.NREQ(2)) bif4 ();
  z80_bus_arbiter_if #(.NREQ(2)) bif0 ();

  z80_bus_arbiter #(.NREQ(2), .CPU_SLOT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .bus(bif4)
  );
  z80_bus_arbiter #(.NREQ(2), .CPU_SLOT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .bus(bif0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t v4[36];
  vec_t v0[9];

  function automatic vec_t mk(input logic [1:0] rq, input logic bk, input logic ce,
                              input logic [1:0] ak, input logic br, input logic oe,
                              input logic [1:0] ow, input logic [15:0] ad);
    vec_t v;
    v.req = rq; v.bak = bk; v.cen = ce; v.ack = ak;
    v.brq = br; v.oe = oe; v.own = ow; v.addr = ad;
    return v;
  endfunction

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got {ack,brq_n,oe,owner,mreqn,addr}=%h required %h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic run_vec(input vec_t v, input bit sel, input int idx);
    logic [22:0] got;
    logic [22:0] exp;
    @(negedge clk);
    cen = v.cen;
    if (sel) begin
      bif0.req = v.req; bif0.cpu_busack_n = v.bak;
    end else begin
      bif4.req = v.req; bif4.cpu_busack_n = v.bak;
    end
    @(posedge clk);
    #1;
    if (sel) got = {bif0.ack, bif0.cpu_busrq_n, bif0.bus_oe, bif0.owner, bif0.sys_obus.mreqn, bif0.sys_obus.addr};
    else     got = {bif4.ack, bif4.cpu_busrq_n, bif4.bus_oe, bif4.owner, bif4.sys_obus.mreqn, bif4.sys_obus.addr};
    exp = {v.ack, v.brq, v.oe, v.own, ~v.oe, v.addr};
    check($sformatf("%s[%0d]", sel ? "slot0" : "slot4", idx), got, exp);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    cen = 1'b1;
    bif4.req = 2'b00; bif4.cpu_busack_n = 1'b1;
    bif0.req = 2'b00; bif0.cpu_busack_n = 1'b1;
    bif4.m_ibus[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h6900, 8'h55};
    bif4.m_ibus[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 8'hAA};
    bif0.m_ibus[0] = bif4.m_ibus[0];
    bif0.m_ibus[1] = bif4.m_ibus[1];

    // Single request, CPU slot, withdrawn request, cen gating (CPU_SLOT=4).
    v4[0]  = mk(2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h0000);
    v4[1]  = mk(2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 16'h0000);
    v4[2]  = mk(2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 16'h0000);
    v4[3]  = mk(2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 2'd1, 16'h6900);
    v4[4]  = mk(2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 2'd1, 16'h6900);
    v4[5]  = mk(2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h6900);
    v4[6]  = mk(2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h6900);
    v4[7]  = mk(2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h6900);
    v4[8]  = mk(2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h6900);
    v4[9]  = mk(2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h6900);
    v4[10] = mk(2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h6900);
    v4[11] = mk(2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 16'h6900);
    v4[12] = mk(2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'd2, 16'h1234);
    v4[13] = mk(2'b11, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'd2, 16'h1234);
    v4[14] = mk(2'b01, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h1234);
    v4[15] = mk(2'b01, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h1234);
    for (int i = 16; i < 20; i++) v4[i] = mk(2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h1234);
    v4[20] = mk(2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 16'h1234);
    v4[21] = mk(2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 16'h1234);
    v4[22] = mk(2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 16'h1234);
    v4[23] = mk(2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h1234);
    v4[24] = mk(2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h1234);
    v4[25] = mk(2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h1234);
    for (int i = 26; i < 29; i++) v4[i] = mk(2'b01, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h1234);
    v4[29] = mk(2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 16'h1234);
    for (int i = 30; i < 35; i++) v4[i] = mk(2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 16'h1234);
    v4[35] = mk(2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 2'd1, 16'h6900);

    // Round-robin with direct handoff (CPU_SLOT=0); each master toggles req low for one cycle.
    v0[0] = mk(2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 16'h0000);
    v0[1] = mk(2'b11, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 2'd1, 16'h6900);
    v0[2] = mk(2'b11, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 2'd1, 16'h6900);
    v0[3] = mk(2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 16'h6900);
    v0[4] = mk(2'b11, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'd2, 16'h1234);
    v0[5] = mk(2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 16'h1234);
    v0[6] = mk(2'b11, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 2'd1, 16'h6900);
    v0[7] = mk(2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h6900);
    v0[8] = mk(2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0, 16'h6900);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {bif4.ack, bif4.cpu_busrq_n, bif4.bus_oe, bif4.owner, bif4.sys_obus.mreqn, bif4.sys_obus.addr},
          {2'b00, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0000});
    n_total++;
    if ({bif4.sys_obus.iorqn, bif4.sys_obus.rdn, bif4.sys_obus.wrn, bif4.sys_obus.inta, bif4.sys_obus.dmaster} !== {4'b1110, 8'h00}) begin
      $display("FAIL reset_ctrl: got %b required %b",
               {bif4.sys_obus.iorqn, bif4.sys_obus.rdn, bif4.sys_obus.wrn, bif4.sys_obus.inta, bif4.sys_obus.dmaster}, {4'b1110, 8'h00});
    end else begin
      n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 36; i++) run_vec(v4[i], 1'b0, i);
    for (int i = 0; i < 9; i++) run_vec(v0[i], 1'b1, i);

    // Mux has zero latency: an address change shows up without a clock edge.
    @(negedge clk);
    bif4.m_ibus[0].addr = 16'h6A00;
    #1;
    check("mux_zero_latency", {bif4.ack, bif4.cpu_busrq_n, bif4.bus_oe, bif4.owner, bif4.sys_obus.mreqn, bif4.sys_obus.addr},
          {2'b01, 1'b0, 1'b1, 2'd1, 1'b0, 16'h6A00});

    // Asynchronous reset mid-grant clears everything before the next clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_grant", {bif4.ack, bif4.cpu_busrq_n, bif4.bus_oe, bif4.owner, bif4.sys_obus.mreqn, bif4.sys_obus.addr},
          {2'b00, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0000});
    n_total++;
    if ({bif4.sys_obus.iorqn, bif4.sys_obus.rdn, bif4.sys_obus.wrn} !== 3'b111) begin
      $display("FAIL reset_mid_grant_ctrl: got %b required 111",
               {bif4.sys_obus.iorqn, bif4.sys_obus.rdn, bif4.sys_obus.wrn});
    end else begin
      n_pass++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/z80_bus_arbiter.md
Name: z80_bus_arbiter

Overview:
Shares the Z80 system bus between the CPU and up to NREQ DMA-style bus masters, for example several DMA engines on one board.
- Collects requester busrq lines and runs the BUSREQ/BUSACK handshake with the CPU.
- Grants the bus to one requester at a time using round-robin priority.
- Muxes the winning master's Z80MasterBus onto the system bus.
- Guarantees the CPU a minimum number of bus cycles between DMA tenures.

Parameters:
NREQ, 2, number of bus requesters (1..8).
CPU_SLOT, 4, cen cycles the CPU owns the bus after each release before any new request is forwarded; 0 allows direct requester-to-requester handoff.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous assert, active-low
cen  input  1  clock enable; all state and outputs advance only on clk edges with cen=1
req  input  NREQ  per-requester bus request (a DMA's busrq), active high
ack  output  NREQ  per-requester bus grant (a DMA's busack), one-hot or zero
m_ibus  input  NREQ x Z80MasterBus  each requester's master-side bus
sys_obus  output  Z80MasterBus  muxed bus from the granted requester
bus_oe  output  1  high while a requester drives sys_obus
cpu_busrq_n  output  1  Z80 BUSREQ, active low
cpu_busack_n  input  1  Z80 BUSACK, active low, already synchronous to clk
owner  output  $clog2(NREQ+1)  0=CPU, i+1=requester i

Behaviour:
- Reset (asynchronous, active-low), all outputs:
  - cpu_busrq_n=1, ack=0, bus_oe=0, owner=0.
  - sys_obus: mreqn=iorqn=rdn=wrn=1, inta=0, addr=0, dmaster=0.
  - state=CPU, rr_ptr=0, slot counter=0.
- Reset mid-grant aborts the tenure immediately; there is no handshake completion.
- States (one-hot):
  - CPU: the CPU owns the bus. Slot counter counts down to 0. When the counter is 0 and |req=1, go to REQ.
  - REQ: cpu_busrq_n=0. Wait for cpu_busack_n=0, then pick the winner and go to GRANT.
    - If req drops to 0 before busack arrives, stay in REQ until busack=0, then go to RELEASE. The Z80 handshake is always completed.
  - GRANT: ack[w]=1, bus_oe=1, owner=w+1, sys_obus=m_ibus[w] (combinational mux, zero latency). Stay while req[w]=1.
    - When req[w]=0: ack[w] falls on the same cen edge and bus_oe drops with it.
    - If CPU_SLOT=0 and another req is pending, go to HANDOFF. Otherwise go to RELEASE.
  - HANDOFF: one idle cycle. Control lines stay high and bus_oe=0; cpu_busrq_n stays 0. Pick the next winner and go to GRANT.
  - RELEASE: cpu_busrq_n=1. Wait for cpu_busack_n=1, then load the slot counter with CPU_SLOT and go to CPU.
- Arbitration:
  - Winner = first asserted req scanning from rr_ptr upward, with wrap-around modulo NREQ.
  - On each grant, rr_ptr <= (w+1) mod NREQ.
  - req is sampled only at REQ exit and at HANDOFF. A req that rises mid-GRANT waits.
- When bus_oe=0, sys_obus control lines are 1 and addr/dmaster hold their last values.
- ack never changes except on a cen=1 edge.
- Latency:
  - req rise to cpu_busrq_n fall: 1 cen cycle, if the slot counter is 0.
  - cpu_busack_n fall to ack rise: 1 cen cycle.
- A requester dropping req while also re-requesting (req toggling low for one cycle) loses its turn under round-robin.
- cpu_busack_n asserting in any state other than REQ or GRANT/HANDOFF is ignored.

Test Plan:
- Single request: NREQ=2, CPU_SLOT=4. Raise req[0] → cpu_busrq_n=0 next cen. Busack low → ack=01, owner=1, sys_obus.addr follows m_ibus[0].addr=6900h. Drop req[0] → ack=00, cpu_busrq_n=1. Busack high → 4 CPU cycles before any new REQ.
- Round-robin: req=11 held, CPU_SLOT=0. Grants alternate 01,10,01 with one HANDOFF idle cycle between tenures; cpu_busrq_n stays 0 throughout.
- CPU slot fairness: CPU_SLOT=4, req[1] re-raised the cycle after release → cpu_busrq_n stays 1 for exactly 4 cen cycles after cpu_busack_n=1.
- Request withdrawn: req[0] pulses for 1 cycle, busack arrives 3 cycles later → ack never asserts, cpu_busrq_n returns to 1, FSM back in CPU.
- cen gating and async reset:
  - cen=0 for 5 cycles during REQ with busack low → no state change.
  - rst_n low mid-GRANT → ack=0, cpu_busrq_n=1, sys_obus control lines=1 before the next clk edge.
